uart_tx_arb: RTL and testbench

//  Shares one uart_tx byte channel among NCH requesters with round-robin arbitration.
//  A grant is held for a whole packet, until the byte flagged req_last or MAX_LEN bytes.
//  An optional tag byte identifying the channel is sent before each packet.

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_tx_arb_if.sv | 21 ++
 rtl/uart_rr_pick.sv | 21 ++
 rtl/uart_tx_arb.sv | 57 +++++
 tb/tb_uart_tx_arb.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared arbiter state type and tag default
package uart_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_TAG, ARB_DATA} arb_state_t;
  localparam logic [3:0] ARB_TAG_PREFIX_DEF = 4'hC;
endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: client byte streams, uart_tx channel and arbiter status
interface uart_tx_arb_if #(parameter int NCH = 4);
  logic             cfg_tag_en;
  logic [NCH-1:0]   req_valid;
  logic [NCH*8-1:0] req_data;
  logic [NCH-1:0]   req_last;
  logic [NCH-1:0]   req_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;
  logic             busy;
  logic [3:0]       grant_id;
  modport master (
    output cfg_tag_en, req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, busy, grant_id
  );
  modport slave (
    input  cfg_tag_en, req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, busy, grant_id
  );
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: first requester found after ptr, searching upward with wrap
module uart_rr_pick #(parameter int NCH = 4) (
  input  logic [NCH-1:0] req,
  input  logic [3:0]     ptr,
  output logic [3:0]     gnt_id,
  output logic           any
);
  logic [2*NCH-1:0] dbl;
  logic             found;
  assign dbl = {req, req};
  assign any = |req;
  always_comb begin
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < 2*NCH; i++)
      if (!found && dbl[i] && i > int'(ptr) && i <= int'(ptr) + NCH) begin
        gnt_id = 4'(i >= NCH ? i - NCH : i);
        found  = 1'b1;
      end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin sharing of one uart_tx byte channel among NCH packet streams
module uart_tx_arb import uart_pkg::*; #(
  parameter int         NCH        = 4,
  parameter int         MAX_LEN    = 64,
  parameter logic [3:0] TAG_PREFIX = ARB_TAG_PREFIX_DEF
) (
  input logic          clk,
  input logic          rst,
  uart_tx_arb_if.slave bus
);
  arb_state_t   state, state_nx;
  logic [3:0]   rr_ptr, grant_id, pick_id;
  logic [15:0]  byte_cnt, valid_pad, last_pad;
  logic [127:0] data_pad;
  logic         pick_any, hs, done;
  assign valid_pad = 16'(bus.req_valid);
  assign last_pad  = 16'(bus.req_last);
  assign data_pad  = 128'(bus.req_data);
  uart_rr_pick #(.NCH(NCH)) u_pick (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .gnt_id (pick_id),
    .any    (pick_any)
  );
  assign hs   = state == ARB_DATA && valid_pad[grant_id] && bus.tx_ready;
  assign done = hs && (last_pad[grant_id] || {1'b0, byte_cnt} + 17'd1 == 17'(MAX_LEN));
  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE: state_nx = pick_any ? (bus.cfg_tag_en ? ARB_TAG : ARB_DATA) : ARB_IDLE;
      ARB_TAG:  state_nx = bus.tx_ready ? ARB_DATA : ARB_TAG;
      ARB_DATA: state_nx = done ? ARB_IDLE : ARB_DATA;
      default:  state_nx = ARB_IDLE;
    endcase
  end
  assign bus.tx_valid  = state == ARB_TAG || (state == ARB_DATA && valid_pad[grant_id]);
  assign bus.tx_data   = state == ARB_TAG  ? {TAG_PREFIX, grant_id} :
                         state == ARB_DATA ? data_pad[{grant_id, 3'b000} +: 8] : 8'h00;
  assign bus.req_ready = (state == ARB_DATA && bus.tx_ready) ? {{(NCH-1){1'b0}}, 1'b1} << grant_id : '0;
  assign bus.busy      = state != ARB_IDLE;
  assign bus.grant_id  = grant_id;
  always_ff @(posedge clk)
    if (rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= 4'(NCH - 1);
      byte_cnt <= '0;
      grant_id <= '0;
    end else begin
      state <= state_nx;
      if (state == ARB_IDLE && pick_any) begin
        grant_id <= pick_id;
        byte_cnt <= '0;
      end
      if (hs) byte_cnt <= &byte_cnt ? byte_cnt : byte_cnt + 16'd1;
      if (done) rr_ptr <= grant_id;
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed and randomized checks of uart_tx_arb against a packet-level model
module tb_uart_tx_arb;
  localparam int NCH  = 4;
  localparam int MAXL = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_tx_arb_if #(.NCH(NCH)) bus();
  uart_tx_arb #(.NCH(NCH), .MAX_LEN(MAXL), .TAG_PREFIX(4'hC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  int n_chk = 0;
  int n_fail = 0;
  logic [8:0] q_src [NCH][$];
  logic [7:0] q_exp [NCH][$];
  logic [7:0] q_tx [$];
  int q_gnt [$];
  logic [NCH-1:0] acc = '0;
  logic [NCH-1:0] hold = '0;
  bit en = 0, gappy = 0, rnd_cfg = 0;
  int txr_mode = 0;
  bit m_act = 0, m_tag = 0;
  int m_own = 0, m_gid = 0, m_cnt = 0, m_ptr = NCH - 1;
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (en) begin
      check("busy", 32'(bus.busy), 32'(m_act));
      check("grant_id", 32'(bus.grant_id), m_gid);
      check("tx_valid", 32'(bus.tx_valid), 32'(m_act && (m_tag || bus.req_valid[m_own])));
      check("req_ready", 32'(bus.req_ready), (m_act && !m_tag && bus.tx_ready) ? 32'(1) << m_own : 32'(0));
      if (m_act && m_tag) check("tag_byte", 32'(bus.tx_data), 32'({4'hC, 4'(m_own)}));
      acc = bus.req_valid & bus.req_ready;
      if (rst) begin
        m_act = 0; m_tag = 0; m_ptr = NCH - 1; m_gid = 0; m_cnt = 0;
        for (int i = 0; i < NCH; i++) q_exp[i].delete();
      end else if (!m_act) begin
        for (int k = 1; k <= NCH && !m_act; k++)
          if (bus.req_valid[(m_ptr + k) % NCH]) begin
            m_act = 1; m_own = (m_ptr + k) % NCH; m_gid = m_own; m_cnt = 0;
            m_tag = bus.cfg_tag_en;
            q_gnt.push_back(m_own);
          end
      end else if (m_tag) begin
        if (bus.tx_ready) begin
          m_tag = 0;
          q_tx.push_back(bus.tx_data);
        end
      end else if (bus.req_valid[m_own] && bus.tx_ready) begin
        if (q_exp[m_own].size() > 0) e = q_exp[m_own].pop_front();
        else e = 'x;
        check("data_stream", 32'(bus.tx_data), 32'(e));
        q_tx.push_back(bus.tx_data);
        m_cnt++;
        if (bus.req_last[m_own] || m_cnt == MAXL) begin
          m_act = 0;
          m_ptr = m_own;
        end
      end
    end
  end
  task automatic drive();
    logic [8:0] f;
    for (int i = 0; i < NCH; i++) begin
      if (acc[i]) begin
        if (q_src[i].size() > 0) void'(q_src[i].pop_front());
        bus.req_valid[i] = 1'b0;
      end
      if (!bus.req_valid[i] && q_src[i].size() > 0 && !hold[i] && (!gappy || $urandom_range(3) != 0)) begin
        f = q_src[i][0];
        bus.req_valid[i] = 1'b1;
        bus.req_data[i*8 +: 8] = f[7:0];
        bus.req_last[i] = f[8];
      end
    end
    bus.tx_ready = txr_mode == 0 ? 1'b1 : txr_mode == 2 ? 1'b0 : 1'($urandom_range(1));
    if (rnd_cfg) bus.cfg_tag_en = 1'($urandom_range(1));
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1 drive();
      #1;
    end
  endtask
  task automatic push(int ch, logic [7:0] d, logic last);
    q_src[ch].push_back({last, d});
    q_exp[ch].push_back(d);
  endtask
  function automatic bit pending();
    pending = bus.busy;
    for (int i = 0; i < NCH; i++) if (q_src[i].size() > 0) pending = 1;
  endfunction
  task automatic wait_done(int max, string nm);
    int c = 0;
    while (pending() && c < max) begin
      tick(1);
      c++;
    end
    check({nm, "_done"}, 32'(c < max), 1);
  endtask
  task automatic wait_grant(int ch, int max, string nm);
    int c = 0;
    while (!(bus.busy && bus.grant_id == 4'(ch)) && c < max) begin
      tick(1);
      c++;
    end
    check({nm, "_grant"}, 32'(c < max), 1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NCH; i++) q_src[i].delete();
    bus.req_valid = '0;
    hold = '0;
    tick(1);
    rst = 1'b0;
  endtask
  initial begin
    logic [7:0] e1 [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] e4 [14] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h71, 8'h72, 8'h45,
                            8'h46, 8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C};
    logic [7:0] e5 [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1};
    int c, len;
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
    bus.tx_ready = 1'b1; bus.cfg_tag_en = 1'b0;
    tick(1);
    en = 1;
    tick(1);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_grant_id", 32'(bus.grant_id), 0);
    q_tx.delete();
    push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
    wait_done(100, "t1");
    check("t1_len", q_tx.size(), 3);
    for (int k = 0; k < 3; k++) check("t1_byte", 32'(q_tx[k]), 32'(e1[k]));
    check("t1_grant_id", 32'(bus.grant_id), 0);
    q_tx.delete();
    bus.cfg_tag_en = 1'b1;
    txr_mode = 2;
    push(2, 8'h5A, 1);
    wait_grant(2, 50, "t2");
    tick(3);
    check("t2_tag_valid", 32'(bus.tx_valid), 1);
    check("t2_tag_data", 32'(bus.tx_data), 32'hC2);
    check("t2_ready_low", 32'(bus.req_ready), 0);
    txr_mode = 0;
    wait_done(100, "t2");
    bus.cfg_tag_en = 1'b0;
    check("t2_len", q_tx.size(), 2);
    check("t2_tag", 32'(q_tx[0]), 32'hC2);
    check("t2_byte", 32'(q_tx[1]), 32'h5A);
    do_reset();
    q_gnt.delete();
    for (int r = 0; r < 4; r++)
      for (int ch = 0; ch < NCH; ch++) begin
        push(ch, 8'(ch * 16 + 2 * r), 0);
        push(ch, 8'(ch * 16 + 2 * r + 1), 1);
      end
    wait_done(500, "t3");
    check("t3_len", q_gnt.size(), 16);
    for (int k = 0; k < 16; k++) check("t3_order", q_gnt[k], k % 4);
    for (int k = 1; k < 16; k++) check("t3_alternate", 32'(q_gnt[k] != q_gnt[k-1]), 1);
    q_tx.delete();
    for (int b = 0; b < 12; b++) push(1, 8'(8'h41 + b), 0);
    wait_grant(1, 50, "t4");
    push(3, 8'h71, 0); push(3, 8'h72, 1);
    wait_done(300, "t4");
    check("t4_len", q_tx.size(), 14);
    for (int k = 0; k < 14; k++) check("t4_byte", 32'(q_tx[k]), 32'(e4[k]));
    q_tx.delete();
    txr_mode = 1;
    for (int b = 0; b < 4; b++) push(0, 8'(8'hA0 + b), 1'(b == 3));
    push(1, 8'hB0, 0); push(1, 8'hB1, 1);
    c = 0;
    while (q_src[0].size() > 2 && c < 200) begin tick(1); c++; end
    check("t5_progress", 32'(c < 200), 1);
    hold[0] = 1'b1;
    repeat (5) begin
      tick(1);
      check("t5_busy", 32'(bus.busy), 1);
      check("t5_grant", 32'(bus.grant_id), 0);
      check("t5_blocked", 32'(bus.req_ready[1]), 0);
    end
    hold[0] = 1'b0;
    wait_done(400, "t5");
    check("t5_len", q_tx.size(), 6);
    for (int k = 0; k < 6; k++) check("t5_byte", 32'(q_tx[k]), 32'(e5[k]));
    gappy = 1;
    rnd_cfg = 1;
    for (int ch = 0; ch < NCH; ch++)
      for (int p = 0; p < 6; p++) begin
        len = $urandom_range(6, 1);
        for (int b = 0; b < len; b++) push(ch, 8'($urandom), 1'(b == len - 1));
      end
    wait_done(8000, "rand");
    gappy = 0;
    rnd_cfg = 0;
    bus.cfg_tag_en = 1'b0;
    txr_mode = 0;
    tick(2);
    for (int b = 0; b < 5; b++) push(2, 8'(8'h60 + b), 1'(b == 4));
    c = 0;
    while (q_src[2].size() > 3 && c < 100) begin tick(1); c++; end
    check("t6_progress", 32'(c < 100), 1);
    do_reset();
    check("t6_busy", 32'(bus.busy), 0);
    check("t6_tx_valid", 32'(bus.tx_valid), 0);
    check("t6_req_ready", 32'(bus.req_ready), 0);
    check("t6_grant_id", 32'(bus.grant_id), 0);
    q_gnt.delete();
    push(2, 8'h70, 1);
    push(0, 8'h80, 1);
    wait_done(100, "t6");
    check("t6_first", q_gnt[0], 0);
    check("t6_second", q_gnt[1], 2);
    c = 0;
    for (int i = 0; i < NCH; i++) c += q_exp[i].size();
    check("all_delivered", c, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
